// File: rtl/jedro_1_defines.sv
// Shared jedro_1 core definitions: datapath widths and memory-arbiter enums.
package jedro_1_defines;

    localparam int XLEN   = 32;
    localparam int NBYTES = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } arb_state_e;

    typedef enum logic {
        IFU,
        LSU
    } arb_owner_e;

endpackage

// File: rtl/jedro_1_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction in flight, LSU first with a bounded-starvation guard for fetch.
module jedro_1_mem_arbiter #(
    parameter int XLEN           = jedro_1_defines::XLEN,
    parameter int NBYTES         = XLEN / 8,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic [XLEN-1:0]   ifu_req_addr_i,
    input  logic [XLEN-1:0]   ifu_req_data_i,
    input  logic [NBYTES-1:0] ifu_req_strobe_i,
    input  logic              ifu_req_write_i,
    input  logic              ifu_req_valid_i,
    output logic              ifu_req_ready_o,
    output logic [XLEN-1:0]   ifu_rsp_data_o,
    output logic              ifu_rsp_error_o,
    output logic              ifu_rsp_valid_o,
    input  logic              ifu_rsp_ready_i,

    input  logic [XLEN-1:0]   lsu_req_addr_i,
    input  logic [XLEN-1:0]   lsu_req_data_i,
    input  logic [NBYTES-1:0] lsu_req_strobe_i,
    input  logic              lsu_req_write_i,
    input  logic              lsu_req_valid_i,
    output logic              lsu_req_ready_o,
    output logic [XLEN-1:0]   lsu_rsp_data_o,
    output logic              lsu_rsp_error_o,
    output logic              lsu_rsp_valid_o,
    input  logic              lsu_rsp_ready_i,

    output logic [XLEN-1:0]   mem_req_addr_o,
    output logic [XLEN-1:0]   mem_req_data_o,
    output logic [NBYTES-1:0] mem_req_strobe_o,
    output logic              mem_req_write_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    input  logic [XLEN-1:0]   mem_rsp_data_i,
    input  logic              mem_rsp_error_i,
    input  logic              mem_rsp_valid_i,
    output logic              mem_rsp_ready_o,

    output logic              protocol_err_o
);
    import jedro_1_defines::*;

    localparam logic [3:0] MAX_CNT = 4'(MAX_DATA_BURST);

    arb_state_e state;
    arb_owner_e owner;
    logic [3:0] burst_cnt;

    logic lsu_wins;
    logic owner_req_valid;
    logic owner_rsp_ready;

    // A saturated counter only blocks the LSU while fetch is actually waiting.
    assign lsu_wins        = lsu_req_valid_i && ((burst_cnt < MAX_CNT) || !ifu_req_valid_i);
    assign owner_req_valid = (owner == LSU) ? lsu_req_valid_i : ifu_req_valid_i;
    assign owner_rsp_ready = (owner == LSU) ? lsu_rsp_ready_i : ifu_rsp_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            owner          <= IFU;
            burst_cnt      <= 4'd0;
            protocol_err_o <= 1'b0;
        end else begin
            if (mem_rsp_valid_i && (state != RSP))
                protocol_err_o <= 1'b1;
            case (state)
                IDLE: begin
                    if (lsu_wins) begin
                        owner <= LSU;
                        state <= REQ;
                        if (ifu_req_valid_i && (burst_cnt < MAX_CNT))
                            burst_cnt <= burst_cnt + 4'd1;
                    end else if (ifu_req_valid_i) begin
                        owner     <= IFU;
                        state     <= REQ;
                        burst_cnt <= 4'd0;
                    end
                end
                REQ: begin
                    if (!owner_req_valid)
                        state <= IDLE;
                    else if (mem_req_ready_i)
                        state <= RSP;
                end
                RSP: begin
                    if (mem_rsp_valid_i && owner_rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req_addr_o   = '0;
        mem_req_data_o   = '0;
        mem_req_strobe_o = '0;
        mem_req_write_o  = 1'b0;
        mem_req_valid_o  = 1'b0;
        mem_rsp_ready_o  = 1'b0;
        ifu_req_ready_o  = 1'b0;
        lsu_req_ready_o  = 1'b0;
        ifu_rsp_data_o   = '0;
        ifu_rsp_error_o  = 1'b0;
        ifu_rsp_valid_o  = 1'b0;
        lsu_rsp_data_o   = '0;
        lsu_rsp_error_o  = 1'b0;
        lsu_rsp_valid_o  = 1'b0;
        case (state)
            IDLE: mem_rsp_ready_o = 1'b1;
            REQ: begin
                // Stray responses are swallowed here so they cannot wedge memory.
                mem_rsp_ready_o = mem_rsp_valid_i;
                if (owner == LSU) begin
                    mem_req_addr_o   = lsu_req_addr_i;
                    mem_req_data_o   = lsu_req_data_i;
                    mem_req_strobe_o = lsu_req_strobe_i;
                    mem_req_write_o  = lsu_req_write_i;
                    mem_req_valid_o  = lsu_req_valid_i;
                    lsu_req_ready_o  = mem_req_ready_i;
                end else begin
                    mem_req_addr_o   = ifu_req_addr_i;
                    mem_req_data_o   = ifu_req_data_i;
                    mem_req_strobe_o = ifu_req_strobe_i;
                    mem_req_write_o  = ifu_req_write_i;
                    mem_req_valid_o  = ifu_req_valid_i;
                    ifu_req_ready_o  = mem_req_ready_i;
                end
            end
            RSP: begin
                mem_rsp_ready_o = owner_rsp_ready;
                if (owner == LSU) begin
                    lsu_rsp_data_o  = mem_rsp_data_i;
                    lsu_rsp_error_o = mem_rsp_error_i;
                    lsu_rsp_valid_o = mem_rsp_valid_i;
                end else begin
                    ifu_rsp_data_o  = mem_rsp_data_i;
                    ifu_rsp_error_o = mem_rsp_error_i;
                    ifu_rsp_valid_o = mem_rsp_valid_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Self-checking bench for jedro_1_mem_arbiter: directed scenarios plus
// randomized masters/memory checked every cycle against a transaction model.
module tb_jedro_1_mem_arbiter;
    localparam int XLEN = jedro_1_defines::XLEN;
    localparam int NB   = XLEN / 8;
    localparam int MAXB = 4;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [XLEN-1:0] ifu_req_addr_i = '0, ifu_req_data_i = '0;
    logic [NB-1:0]   ifu_req_strobe_i = '0;
    logic            ifu_req_write_i = 1'b0, ifu_req_valid_i = 1'b0, ifu_rsp_ready_i = 1'b0;
    logic [XLEN-1:0] lsu_req_addr_i = '0, lsu_req_data_i = '0;
    logic [NB-1:0]   lsu_req_strobe_i = '0;
    logic            lsu_req_write_i = 1'b0, lsu_req_valid_i = 1'b0, lsu_rsp_ready_i = 1'b0;
    logic            mem_req_ready_i = 1'b0;
    logic [XLEN-1:0] mem_rsp_data_i = '0;
    logic            mem_rsp_error_i = 1'b0, mem_rsp_valid_i = 1'b0;

    logic            ifu_req_ready_o, ifu_rsp_error_o, ifu_rsp_valid_o;
    logic [XLEN-1:0] ifu_rsp_data_o;
    logic            lsu_req_ready_o, lsu_rsp_error_o, lsu_rsp_valid_o;
    logic [XLEN-1:0] lsu_rsp_data_o;
    logic [XLEN-1:0] mem_req_addr_o, mem_req_data_o;
    logic [NB-1:0]   mem_req_strobe_o;
    logic            mem_req_write_o, mem_req_valid_o, mem_rsp_ready_o, protocol_err_o;

    jedro_1_mem_arbiter #(.MAX_DATA_BURST(MAXB)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifu_req_addr_i(ifu_req_addr_i), .ifu_req_data_i(ifu_req_data_i),
        .ifu_req_strobe_i(ifu_req_strobe_i), .ifu_req_write_i(ifu_req_write_i),
        .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
        .ifu_rsp_data_o(ifu_rsp_data_o), .ifu_rsp_error_o(ifu_rsp_error_o),
        .ifu_rsp_valid_o(ifu_rsp_valid_o), .ifu_rsp_ready_i(ifu_rsp_ready_i),
        .lsu_req_addr_i(lsu_req_addr_i), .lsu_req_data_i(lsu_req_data_i),
        .lsu_req_strobe_i(lsu_req_strobe_i), .lsu_req_write_i(lsu_req_write_i),
        .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_rsp_data_o(lsu_rsp_data_o), .lsu_rsp_error_o(lsu_rsp_error_o),
        .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rsp_ready_i(lsu_rsp_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
        .mem_req_strobe_o(mem_req_strobe_o), .mem_req_write_o(mem_req_write_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_error_i(mem_rsp_error_i),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
        .protocol_err_o(protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;

    // Stimulus knobs (percent probabilities) and request budgets.
    int p_req = 100, p_drop = 0, p_mrdy = 100, p_rrdy_ifu = 100, p_rrdy_lsu = 100;
    int p_resp = 100, p_stray = 0;
    int ifu_target = 0, lsu_target = 0, ifu_issued = 0, lsu_issued = 0;
    bit fix_ifu = 0, fix_rsp = 0;
    logic [XLEN-1:0] fix_addr = '0, fix_word = '0;
    bit glog[$];
    bit ihs, lhs, macc, mnew, pend;

    // Transaction-level model: phase 0 = waiting for a grant, 1 = request
    // offered to memory, 2 = awaiting the response; m_own 1 means LSU.
    int m_st = 0, m_cnt = 0;
    bit m_own = 0, m_err = 0;
    bit ov, orr, lwin;
    int st_prev;

    function automatic bit rnd(int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        chk(name, XLEN'(act), XLEN'(exp));
    endtask

    bit found;
    logic [XLEN-1:0] addr_ref;
    bit exp_order [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};

    initial begin
        fork
            // Master and memory agents: sample handshakes on the falling edge,
            // update inputs just after the rising edge.
            forever begin
                @(negedge clk_i);
                ihs  = ifu_req_valid_i && ifu_req_ready_o;
                lhs  = lsu_req_valid_i && lsu_req_ready_o;
                macc = mem_rsp_valid_i && mem_rsp_ready_o;
                mnew = mem_req_valid_o && mem_req_ready_i;
                if (ihs) glog.push_back(1'b0);
                if (lhs) glog.push_back(1'b1);
                @(posedge clk_i);
                #1;
                if (rst_i) begin
                    ifu_req_valid_i = 0; lsu_req_valid_i = 0; mem_rsp_valid_i = 0; pend = 0;
                end else begin
                    if (ihs) begin ifu_issued++; ifu_req_valid_i = 0; end
                    else if (ifu_req_valid_i && rnd(p_drop)) ifu_req_valid_i = 0;
                    if (!ifu_req_valid_i && ifu_issued < ifu_target && rnd(p_req)) begin
                        ifu_req_valid_i  = 1;
                        ifu_req_addr_i   = fix_ifu ? fix_addr : $urandom;
                        ifu_req_data_i   = $urandom;
                        ifu_req_strobe_i = NB'($urandom);
                        ifu_req_write_i  = fix_ifu ? 1'b0 : 1'($urandom);
                    end
                    if (lhs) begin lsu_issued++; lsu_req_valid_i = 0; end
                    else if (lsu_req_valid_i && rnd(p_drop)) lsu_req_valid_i = 0;
                    if (!lsu_req_valid_i && lsu_issued < lsu_target && rnd(p_req)) begin
                        lsu_req_valid_i  = 1;
                        lsu_req_addr_i   = $urandom;
                        lsu_req_data_i   = $urandom;
                        lsu_req_strobe_i = NB'($urandom);
                        lsu_req_write_i  = 1'($urandom);
                    end
                    ifu_rsp_ready_i = rnd(p_rrdy_ifu);
                    lsu_rsp_ready_i = rnd(p_rrdy_lsu);
                    mem_req_ready_i = rnd(p_mrdy);
                    if (macc) mem_rsp_valid_i = 0;
                    if (mnew) pend = 1;
                    if (!mem_rsp_valid_i) begin
                        if (pend && rnd(p_resp)) begin
                            mem_rsp_valid_i = 1; pend = 0;
                            mem_rsp_data_i  = fix_rsp ? fix_word : $urandom;
                            mem_rsp_error_i = fix_rsp ? 1'b0 : rnd(20);
                        end else if (rnd(p_stray)) begin
                            mem_rsp_valid_i = 1; mem_rsp_data_i = $urandom; mem_rsp_error_i = 0;
                        end
                    end
                end
            end
            // Compare process: every falling edge against the model.
            forever begin
                @(negedge clk_i or posedge rst_i);
                if (rst_i) begin m_st = 0; m_own = 0; m_cnt = 0; m_err = 0; end
                if (clk_i == 1'b0) begin
                    ov  = m_own ? lsu_req_valid_i : ifu_req_valid_i;
                    orr = m_own ? lsu_rsp_ready_i : ifu_rsp_ready_i;
                    chk1("mem_req_valid", mem_req_valid_o, m_st == 1 && ov);
                    chk("mem_req_addr", mem_req_addr_o, m_st != 1 ? '0 : m_own ? lsu_req_addr_i : ifu_req_addr_i);
                    chk("mem_req_data", mem_req_data_o, m_st != 1 ? '0 : m_own ? lsu_req_data_i : ifu_req_data_i);
                    chk("mem_req_strobe", XLEN'(mem_req_strobe_o),
                        m_st != 1 ? '0 : XLEN'(m_own ? lsu_req_strobe_i : ifu_req_strobe_i));
                    chk1("mem_req_write", mem_req_write_o, m_st == 1 && (m_own ? lsu_req_write_i : ifu_req_write_i));
                    chk1("ifu_req_ready", ifu_req_ready_o, m_st == 1 && !m_own && mem_req_ready_i);
                    chk1("lsu_req_ready", lsu_req_ready_o, m_st == 1 && m_own && mem_req_ready_i);
                    chk1("ifu_rsp_valid", ifu_rsp_valid_o, m_st == 2 && !m_own && mem_rsp_valid_i);
                    chk1("lsu_rsp_valid", lsu_rsp_valid_o, m_st == 2 && m_own && mem_rsp_valid_i);
                    chk("ifu_rsp_data", ifu_rsp_data_o, (m_st == 2 && !m_own) ? mem_rsp_data_i : '0);
                    chk("lsu_rsp_data", lsu_rsp_data_o, (m_st == 2 && m_own) ? mem_rsp_data_i : '0);
                    chk1("ifu_rsp_error", ifu_rsp_error_o, m_st == 2 && !m_own && mem_rsp_error_i);
                    chk1("lsu_rsp_error", lsu_rsp_error_o, m_st == 2 && m_own && mem_rsp_error_i);
                    chk1("mem_rsp_ready", mem_rsp_ready_o,
                         m_st == 0 ? 1'b1 : m_st == 1 ? mem_rsp_valid_i : orr);
                    chk1("protocol_err", protocol_err_o, m_err);
                    if (!rst_i) begin
                        st_prev = m_st;
                        if (m_st == 0) begin
                            lwin = lsu_req_valid_i && (m_cnt < MAXB || !ifu_req_valid_i);
                            if (lwin) begin
                                m_own = 1; m_st = 1;
                                if (ifu_req_valid_i) m_cnt = (m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1;
                            end else if (ifu_req_valid_i) begin
                                m_own = 0; m_st = 1; m_cnt = 0;
                            end
                        end else if (m_st == 1) begin
                            if (!ov) m_st = 0;
                            else if (mem_req_ready_i) m_st = 2;
                        end else if (mem_rsp_valid_i && orr) begin
                            m_st = 0;
                        end
                        if (mem_rsp_valid_i && st_prev != 2) m_err = 1;
                    end
                end
            end
        join_none

        // Reset values
        repeat (2) @(posedge clk_i);
        #2 rst_i = 0;
        @(negedge clk_i);
        chk1("rst_mem_rsp_ready", mem_rsp_ready_o, 1'b1);
        chk1("rst_mem_req_valid", mem_req_valid_o, 1'b0);
        chk1("rst_protocol_err", protocol_err_o, 1'b0);
        chk("rst_mem_req_addr", mem_req_addr_o, '0);

        // IFU read, 3-cycle turnaround
        fix_ifu = 1; fix_addr = 32'h8000_0000; fix_rsp = 1; fix_word = 32'h0000_0013;
        ifu_target = 1;
        @(negedge clk_i);
        chk1("t1_idle_no_req", mem_req_valid_o, 1'b0);
        @(negedge clk_i);
        chk1("t1_req_valid", mem_req_valid_o, 1'b1);
        chk("t1_req_addr", mem_req_addr_o, 32'h8000_0000);
        chk1("t1_ifu_ready", ifu_req_ready_o, 1'b1);
        chk1("t1_lsu_ready", lsu_req_ready_o, 1'b0);
        @(negedge clk_i);
        chk1("t1_rsp_valid", ifu_rsp_valid_o, 1'b1);
        chk("t1_rsp_data", ifu_rsp_data_o, 32'h0000_0013);
        chk1("t1_rsp_error", ifu_rsp_error_o, 1'b0);
        chk1("t1_lsu_no_rsp", lsu_rsp_valid_o, 1'b0);
        @(negedge clk_i);
        chk1("t1_back_idle_req", mem_req_valid_o, 1'b0);
        chk1("t1_back_idle_rdy", mem_rsp_ready_o, 1'b1);
        fix_ifu = 0; fix_rsp = 0;

        // Simultaneous requests: LSU first
        glog.delete();
        ifu_target++; lsu_target++;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk_i);
            if (glog.size() >= 2) found = 1;
        end
        chk1("t2_timeout", found, 1'b1);
        if (found) begin
            chk1("t2_first_lsu", glog[0], 1'b1);
            chk1("t2_second_ifu", glog[1], 1'b0);
        end
        repeat (4) @(negedge clk_i);

        // Burst limit: LSU x4 then IFU, counter cleared, repeat
        glog.delete();
        lsu_target += 10; ifu_target += 2;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk_i);
            if (glog.size() >= 12) found = 1;
        end
        chk1("t3_timeout", found, 1'b1);
        if (found)
            for (int i = 0; i < 12; i++) chk1($sformatf("t3_grant%0d", i), glog[i], exp_order[i]);
        repeat (4) @(negedge clk_i);

        // Memory stall in REQ, then master stall in RSP
        p_mrdy = 0; p_rrdy_lsu = 0; lsu_target++;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            if (mem_req_valid_o) found = 1;
        end
        chk1("t4_req_timeout", found, 1'b1);
        addr_ref = lsu_req_addr_i;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk1("t4_stall_valid", mem_req_valid_o, 1'b1);
            chk("t4_stall_addr", mem_req_addr_o, addr_ref);
            chk1("t4_stall_lsu_rdy", lsu_req_ready_o, 1'b0);
            chk1("t4_stall_ifu_rdy", ifu_req_ready_o, 1'b0);
        end
        p_mrdy = 100;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            if (lsu_rsp_valid_o) found = 1;
        end
        chk1("t4_rsp_timeout", found, 1'b1);
        chk1("t4_rsp_blocked", mem_rsp_ready_o, 1'b0);
        @(negedge clk_i);
        chk1("t4_rsp_held", lsu_rsp_valid_o, 1'b1);
        chk1("t4_rsp_blocked2", mem_rsp_ready_o, 1'b0);
        p_rrdy_lsu = 100;
        repeat (4) @(negedge clk_i);

        // Stray response in IDLE
        p_stray = 100;
        @(negedge clk_i);
        p_stray = 0;
        chk1("t5_stray_ready", mem_rsp_ready_o, 1'b1);
        chk1("t5_no_ifu_rsp", ifu_rsp_valid_o, 1'b0);
        chk1("t5_no_lsu_rsp", lsu_rsp_valid_o, 1'b0);
        chk1("t5_err_not_yet", protocol_err_o, 1'b0);
        @(negedge clk_i);
        chk1("t5_err_set", protocol_err_o, 1'b1);
        repeat (2) @(negedge clk_i);
        chk1("t5_err_sticky", protocol_err_o, 1'b1);

        // Reset while a response is pending
        p_rrdy_ifu = 0; ifu_target++;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            if (ifu_req_valid_i && ifu_req_ready_o) found = 1;
        end
        chk1("t6_req_timeout", found, 1'b1);
        @(posedge clk_i);
        #2;
        chk1("t6_pre_rsp_valid", ifu_rsp_valid_o, 1'b1);
        rst_i = 1;
        #1;
        chk1("t6_rst_rsp_valid", ifu_rsp_valid_o, 1'b0);
        chk("t6_rst_rsp_data", ifu_rsp_data_o, '0);
        chk1("t6_rst_req_valid", mem_req_valid_o, 1'b0);
        chk1("t6_rst_mem_rdy", mem_rsp_ready_o, 1'b1);
        chk1("t6_rst_err", protocol_err_o, 1'b0);
        @(posedge clk_i);
        #3 rst_i = 0;
        @(negedge clk_i);
        p_rrdy_ifu = 100; ifu_target++;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            if (ifu_rsp_valid_o && ifu_rsp_ready_i) found = 1;
        end
        chk1("t6_fresh_ifu_done", found, 1'b1);
        repeat (3) @(negedge clk_i);

        // Randomized traffic, model-checked every cycle
        p_req = 60; p_drop = 5; p_mrdy = 60; p_rrdy_ifu = 70; p_rrdy_lsu = 70;
        p_resp = 60; p_stray = 2;
        ifu_target += 400; lsu_target += 400;
        repeat (3000) @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
